// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory access arbiter: FSM encoding, owner ids
// and the wait/starve counter width.
package dm_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

endpackage

// File: rtl/dm_arb_wait_ctr.sv
// Loadable down-counter that times the memory wait states; o_zero marks the
// final cycle of an access.
module dm_arb_wait_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and an external
// loader port. Define DM_ARB_STATS_EN to add access/stall counter outputs.
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_done,
    output logic        o_stall,
    input  logic        i_ext_req,
    input  logic        i_ext_we,
    input  logic [31:0] i_ext_addr,
    input  logic [31:0] i_ext_wdata,
    output logic        o_ext_gnt,
    output logic [31:0] o_ext_rdata,
    output logic        o_ext_done,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
`ifdef DM_ARB_STATS_EN
    output logic [31:0] o_cpu_acc_cnt,
    output logic [31:0] o_ext_acc_cnt,
    output logic [31:0] o_stall_cnt,
`endif
    output logic [1:0]  o_dbg_state
);

    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic ctr_load, ctr_dec, ctr_zero;
    logic grant_ext;
    logic busy, done;

    dm_arb_wait_ctr #(
        .CNT_W (CNT_W)
    ) u_wait_ctr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (ctr_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (ctr_dec),
        .o_zero     (ctr_zero)
    );

    // CPU wins a tie unless EXT has already lost STARVE_MAX times in a row.
    assign grant_ext = i_ext_req & (~i_cpu_req | (starve_q == STARVE_LIM));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cpu_req | i_ext_req) begin
                    state_d  = ST_BUSY;
                    ctr_load = 1'b1;
                    rdata_d  = '0;
                    if (grant_ext) begin
                        owner_d  = OWN_EXT;
                        we_d     = i_ext_we;
                        addr_d   = i_ext_addr;
                        wdata_d  = i_ext_wdata;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = i_cpu_we;
                        addr_d  = i_cpu_addr;
                        wdata_d = i_cpu_wdata;
                        if (i_ext_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (ctr_zero) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);

    assign o_mem_re    = busy & ~we_q;
    assign o_mem_we    = busy & we_q;
    assign o_mem_addr  = busy ? addr_q : '0;
    assign o_mem_wdata = busy ? wdata_q : '0;

    assign o_cpu_done  = done & (owner_q == OWN_CPU);
    assign o_ext_done  = done & (owner_q == OWN_EXT);
    assign o_cpu_rdata = o_cpu_done ? rdata_q : '0;
    assign o_ext_rdata = o_ext_done ? rdata_q : '0;
    assign o_ext_gnt   = (busy | done) & (owner_q == OWN_EXT);

    // Stall holds while EXT owns memory, since the CPU request is still pending.
    assign o_stall     = i_cpu_req & ~o_cpu_done;
    assign o_dbg_state = state_q;

`ifdef DM_ARB_STATS_EN
    logic [31:0] cpu_acc_q, ext_acc_q, stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cpu_acc_q   <= '0;
            ext_acc_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            cpu_acc_q   <= cpu_acc_q + {31'd0, o_cpu_done};
            ext_acc_q   <= ext_acc_q + {31'd0, o_ext_done};
            stall_cnt_q <= stall_cnt_q + {31'd0, o_stall};
        end
    end

    assign o_cpu_acc_cnt = cpu_acc_q;
    assign o_ext_acc_cnt = ext_acc_q;
    assign o_stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter (WAIT_CYCLES=2, STARVE_MAX=4); the
// counter test is built only when DM_ARB_STATS_EN is defined.
module tb_dm_access_arbiter;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done, stall;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_done;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  dbg_state;
`ifdef DM_ARB_STATS_EN
    logic [31:0] cpu_acc_cnt, ext_acc_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_access_arbiter #(
        .WAIT_CYCLES (WC),
        .STARVE_MAX  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_done  (cpu_done),
        .o_stall     (stall),
        .i_ext_req   (ext_req),
        .i_ext_we    (ext_we),
        .i_ext_addr  (ext_addr),
        .i_ext_wdata (ext_wdata),
        .o_ext_gnt   (ext_gnt),
        .o_ext_rdata (ext_rdata),
        .o_ext_done  (ext_done),
        .o_mem_re    (mem_re),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
`ifdef DM_ARB_STATS_EN
        .o_cpu_acc_cnt (cpu_acc_cnt),
        .o_ext_acc_cnt (ext_acc_cnt),
        .o_stall_cnt   (stall_cnt),
`endif
        .o_dbg_state (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0]  flags;
        logic [31:0] buses;
        rst = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            flags = {mem_re, mem_we, cpu_done, ext_done, ext_gnt, stall};
            buses = mem_addr | mem_wdata | cpu_rdata | ext_rdata;
            total++;
            if (flags !== 6'd0) begin
                bad++;
                $display("FAIL reset_flags[%0d]: got %b want 000000", k, flags);
            end
            total++;
            if (buses !== 32'd0) begin
                bad++;
                $display("FAIL reset_buses[%0d]: got %h want 0", k, buses);
            end
            total++;
            if (dbg_state !== 2'd0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got %0d want 0", k, dbg_state);
            end
            rst = 1'b0;
            step();
        end
    endtask

    // One isolated access from a single requester; counts strobes, stall and
    // grant cycles and locates the done pulse relative to the request cycle.
    task automatic run_single(input string nm, input logic is_ext, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] memd, input logic [31:0] exp_rdata,
                              input int exp_stall, input int exp_gnt);
        int re_n = 0, we_n = 0, stall_n = 0, gnt_n = 0, done_n = 0, done_c = -1;
        logic d, od;
        logic [31:0] rd, ord;
        mem_rdata = memd;
        if (is_ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int c = 0; c < 8; c++) begin
            #1;
            d   = is_ext ? ext_done : cpu_done;
            od  = is_ext ? cpu_done : ext_done;
            rd  = is_ext ? ext_rdata : cpu_rdata;
            ord = is_ext ? cpu_rdata : ext_rdata;
            if (mem_re) re_n++;
            if (mem_we) we_n++;
            if (stall) stall_n++;
            if (ext_gnt) gnt_n++;
            if (mem_re || mem_we) begin
                total++;
                if (mem_addr !== addr || mem_wdata !== wdata) begin
                    bad++;
                    $display("FAIL %s_membus c%0d: got %h/%h want %h/%h", nm, c,
                             mem_addr, mem_wdata, addr, wdata);
                end
            end
            total++;
            if (od !== 1'b0) begin
                bad++;
                $display("FAIL %s_other_done c%0d: got %b want 0", nm, c, od);
            end
            if (d) begin
                done_n++;
                done_c = c;
                total++;
                if (rd !== exp_rdata || ord !== 32'd0) begin
                    bad++;
                    $display("FAIL %s_rdata: got %h (other %h) want %h (other 0)", nm,
                             rd, ord, exp_rdata);
                end
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end
            step();
        end
        total++;
        if (re_n !== (we ? 0 : WC) || we_n !== (we ? WC : 0)) begin
            bad++;
            $display("FAIL %s_strobes: got re=%0d we=%0d want re=%0d we=%0d", nm, re_n,
                     we_n, we ? 0 : WC, we ? WC : 0);
        end
        total++;
        if (done_n !== 1 || done_c !== WC + 1) begin
            bad++;
            $display("FAIL %s_done: got n=%0d at c%0d want n=1 at c%0d", nm, done_n,
                     done_c, WC + 1);
        end
        total++;
        if (stall_n !== exp_stall || gnt_n !== exp_gnt) begin
            bad++;
            $display("FAIL %s_stall_gnt: got stall=%0d gnt=%0d want stall=%0d gnt=%0d",
                     nm, stall_n, gnt_n, exp_stall, exp_gnt);
        end
        cpu_we = 1'b0; ext_we = 1'b0;
    endtask

    task automatic test_cpu_read();
        run_single("cpu_rd", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0);
    endtask

    task automatic test_cpu_write();
        run_single("cpu_wr", 1'b0, 1'b1, 32'h20, 32'h12345678, 32'hFFFF_FFFF, 32'h0, 3, 0);
    endtask

    task automatic test_ext_read();
        run_single("ext_rd", 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE0001, 32'hCAFE0001, 0, 3);
    endtask

    task automatic test_starvation();
        logic seq[10];
        int   n = 0;
        cpu_req = 1'b1; cpu_addr = 32'h100;
        ext_req = 1'b1; ext_addr = 32'h200;
        mem_rdata = 32'h0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            #1;
            if (cpu_done && ext_done) begin
                total++;
                bad++;
                $display("FAIL starve_both_done c%0d: got 1/1 want one owner", c);
            end
            if (cpu_done) begin seq[n] = 1'b0; n++; end
            else if (ext_done) begin seq[n] = 1'b1; n++; end
            if (n == 10) begin
                cpu_req = 1'b0;
                ext_req = 1'b0;
            end
            step();
        end
        total++;
        if (n !== 10) begin
            bad++;
            $display("FAIL starve_timeout: got %0d grants want 10", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (seq[i] !== ((i % 5) == 4)) begin
                bad++;
                $display("FAIL starve_grant[%0d]: got ext=%b want ext=%b", i, seq[i],
                         (i % 5) == 4);
            end
        end
    endtask

    task automatic test_ext_then_cpu();
        logic [3:0] got, exp;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h300;
        cpu_we = 1'b0; cpu_addr = 32'h400;
        mem_rdata = 32'hA5A5_0001;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) cpu_req = 1'b1;
            #1;
            got = {stall, ext_gnt, ext_done, cpu_done};
            exp = {(c >= 1 && c <= 6), (c >= 1 && c <= 3), (c == 3), (c == 7)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL ext_cpu_flags c%0d: got %b want %b", c, got, exp);
            end
            if (c == 5) begin
                total++;
                if (mem_re !== 1'b1 || mem_addr !== 32'h400) begin
                    bad++;
                    $display("FAIL ext_cpu_bus c5: got re=%b addr=%h want re=1 addr=400",
                             mem_re, mem_addr);
                end
            end
            if (c == 3) begin
                total++;
                if (ext_rdata !== 32'hA5A5_0001 || cpu_rdata !== 32'd0) begin
                    bad++;
                    $display("FAIL ext_cpu_extdata: got %h/%h want a5a50001/0", ext_rdata,
                             cpu_rdata);
                end
                ext_req = 1'b0;
                mem_rdata = 32'h0BAD_F00D;
            end
            if (c == 7) begin
                total++;
                if (cpu_rdata !== 32'h0BAD_F00D || ext_rdata !== 32'd0) begin
                    bad++;
                    $display("FAIL ext_cpu_cpudata: got %h/%h want 0badf00d/0", cpu_rdata,
                             ext_rdata);
                end
                cpu_req = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
        mem_rdata = 32'h11;
        for (int c = 0; c < 9; c++) begin
            #1;
            total++;
            if (cpu_done !== (c == 3 || c == 7)) begin
                bad++;
                $display("FAIL b2b_done c%0d: got %b want %b", c, cpu_done,
                         (c == 3 || c == 7));
            end
            if (c == 3) mem_rdata = 32'h22;
            if (c == 7) begin
                total++;
                if (cpu_rdata !== 32'h22) begin
                    bad++;
                    $display("FAIL b2b_rdata: got %h want 22", cpu_rdata);
                end
                cpu_req = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_mid_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55AA;
        step();
        total++;
        if (mem_we !== 1'b1 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL rstmid_busy: got we=%b state=%0d want we=1 state=1", mem_we,
                     dbg_state);
        end
        rst = 1'b1;
        step();
        total++;
        if (mem_we !== 1'b0 || dbg_state !== 2'd0 || cpu_done !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_abort: got we=%b state=%0d done=%b want 0/0/0", mem_we,
                     dbg_state, cpu_done);
        end
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (cpu_done !== 1'b0 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_after c%0d: got done=%b we=%b want 0/0", c, cpu_done,
                         mem_we);
            end
        end
    endtask

`ifdef DM_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++;
        if (cpu_acc_cnt !== 0 || ext_acc_cnt !== 0 || stall_cnt !== 0) begin
            bad++;
            $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", cpu_acc_cnt,
                     ext_acc_cnt, stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            run_single("st_rd", 1'b0, 1'b0, 32'h600 + i, 32'h0, 32'h77 + i, 32'h77 + i, 3, 0);
        end
        run_single("st_wr", 1'b1, 1'b1, 32'h700, 32'hABCD, 32'h0, 32'h0, 0, 3);
        total++;
        if (cpu_acc_cnt !== 3 || ext_acc_cnt !== 1 || stall_cnt !== 9) begin
            bad++;
            $display("FAIL stats_counts: got %0d/%0d/%0d want 3/1/9", cpu_acc_cnt,
                     ext_acc_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_ext_read();
        test_starvation();
        test_ext_then_cpu();
        test_back_to_back();
        test_reset_mid_write();
`ifdef DM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
